// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : reg_arb_pkg
// Purpose  : Shared types and default widths for the register bank arbiter.
// Revision : 1.0  initial release
// ============================================================================
package reg_arb_pkg;

  // Default widths; the buffered hardware write record is built from these.
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  // Arbiter lock state: OPEN drains, LOCKED holds off, STUCK drains on timeout.
  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    LOCKED = 2'd1,
    STUCK  = 2'd2
  } arb_state_t;

  // One buffered hardware write: target register and data.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } hw_wr_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wr_fifo
// Purpose  : Small synchronous FIFO of hardware write records. Pointers wrap
//            naturally because the depth is a power of two.
// Revision : 1.0  initial release
// ============================================================================
module wr_fifo
  import reg_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  hw_wr_t                       push_data,
  input  logic                         pop,
  output hw_wr_t                       head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  hw_wr_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave count as is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Register bank whose single write port is shared between host
//            (I2C) writes, which always win, and buffered hardware writes,
//            which are held off while a host transaction is in flight.
// Revision : 1.0  initial release
// ============================================================================
module reg_bank_arbiter #(
  parameter int                    NUM_REGS    = 4,
  parameter int                    DATA_W      = reg_arb_pkg::DATA_W,
  parameter int                    SEL_W       = reg_arb_pkg::SEL_W,
  parameter int                    FIFO_DEPTH  = 2,
  parameter logic [NUM_REGS-1:0]   HW_MASK     = 4'b1100,
  parameter int                    TIMEOUT_CYC = 1000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i2c_busy,
  input  logic                         i2c_we,
  input  logic [SEL_W-1:0]             i2c_sel,
  input  logic [DATA_W-1:0]            i2c_wdata,
  input  logic                         hw_valid,
  input  logic [SEL_W-1:0]             hw_sel,
  input  logic [DATA_W-1:0]            hw_wdata,
  output logic                         hw_ready,
  output logic                         hw_err,
  output logic                         lock_timeout,
  output logic [NUM_REGS*DATA_W-1:0]   registers_packed
);

  import reg_arb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC+1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [TMR_W-1:0]  timer;
  logic              drain_ok;

  logic [DATA_W-1:0] bank [NUM_REGS];

  hw_wr_t            push_entry;
  hw_wr_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept;
  logic              hw_allowed;
  logic              fifo_push;
  logic              fifo_pop;

  // Readiness comes only from the registered count, never from a same-cycle pop.
  assign hw_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  // fifo_full is the same registered condition, seen from the FIFO side.
  assign accept     = hw_valid && !fifo_full;
  assign hw_allowed = HW_MASK[hw_sel];
  // Forbidden targets are acknowledged but dropped; hw_err reports them.
  assign fifo_push  = accept && hw_allowed;
  // Host strobe owns the write port; the head only drains on idle cycles.
  assign fifo_pop   = !i2c_we && !fifo_empty && drain_ok;

  assign push_entry.sel  = hw_sel;
  assign push_entry.data = hw_wdata;

  wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Lock state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= OPEN;
    else          state <= next_state;
  end

  // Next-state and drain/timeout outputs; STUCK drains to avoid starving hardware.
  always_comb begin
    next_state   = state;
    drain_ok     = 1'b1;
    lock_timeout = 1'b0;
    case (state)
      OPEN: begin
        if (i2c_busy) next_state = LOCKED;
      end
      LOCKED: begin
        drain_ok = 1'b0;
        if (!i2c_busy)                               next_state = OPEN;
        else if (timer == TMR_W'(TIMEOUT_CYC - 1))   next_state = STUCK;
      end
      STUCK: begin
        lock_timeout = 1'b1;
        if (!i2c_busy) next_state = OPEN;
      end
      default: next_state = OPEN;
    endcase
  end

  // Timeout counter runs only while LOCKED and is zero on entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             timer <= '0;
    else if (state == LOCKED) timer <= timer + 1'b1;
    else                      timer <= '0;
  end

  // Forbidden-target error pulse, one cycle after the accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hw_err <= 1'b0;
    else          hw_err <= accept && !hw_allowed;
  end

  // Single bank write port: host first, else the FIFO head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) bank[k] <= '0;
    end else if (i2c_we) begin
      bank[i2c_sel] <= i2c_wdata;
    end else if (fifo_pop) begin
      bank[head.sel] <= head.data;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
    assign registers_packed[k*DATA_W +: DATA_W] = bank[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Purpose  : Directed, table-driven bench for reg_bank_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_we = 1'b0;
  logic [1:0]  i2c_sel = '0;
  logic [7:0]  i2c_wdata = '0;
  logic        hw_valid = 1'b0;
  logic [1:0]  hw_sel = '0;
  logic [7:0]  hw_wdata = '0;
  logic        hw_ready;
  logic        hw_err;
  logic        lock_timeout;
  logic [31:0] registers_packed;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [7:0]  wd;
    logic        busy;
    logic        hv;
    logic [1:0]  hs;
    logic [7:0]  hd;
    logic [31:0] exp_regs;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  reg_bank_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .i2c_busy         (i2c_busy),
    .i2c_we           (i2c_we),
    .i2c_sel          (i2c_sel),
    .i2c_wdata        (i2c_wdata),
    .hw_valid         (hw_valid),
    .hw_sel           (hw_sel),
    .hw_wdata         (hw_wdata),
    .hw_ready         (hw_ready),
    .hw_err           (hw_err),
    .lock_timeout     (lock_timeout),
    .registers_packed (registers_packed)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sel, input logic [7:0] wd,
                       input logic busy, input logic hv, input logic [1:0] hs,
                       input logic [7:0] hd);
    i2c_we    = we;
    i2c_sel   = sel;
    i2c_wdata = wd;
    i2c_busy  = busy;
    hw_valid  = hv;
    hw_sel    = hs;
    hw_wdata  = hd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sel, input logic [7:0] wd,
                              input logic busy, input logic hv, input logic [1:0] hs,
                              input logic [7:0] hd, input logic [31:0] er,
                              input logic rdy, input logic err, input logic to);
    vec_t v;
    v.we = we; v.sel = sel; v.wd = wd; v.busy = busy;
    v.hv = hv; v.hs = hs; v.hd = hd;
    v.exp_regs = er; v.exp_ready = rdy; v.exp_err = err; v.exp_to = to;
    return v;
  endfunction

  initial begin
    // Each row: inputs held for one cycle, expected outputs just after the edge.
    // Host write reg1, hardware write reg3 while idle.
    vecs[0]  = mk(1, 1, 8'hA5, 0, 0, 0, 8'h00, 32'h0000A500, 1, 0, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0000A500, 1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 1, 3, 8'h3C, 32'h0000A500, 1, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h3C00A500, 1, 0, 0);
    // Busy: fill FIFO, third request refused, nothing drains while locked.
    vecs[4]  = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h3C00A500, 1, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 1, 1, 2, 8'h11, 32'h3C00A500, 1, 0, 0);
    vecs[6]  = mk(0, 0, 8'h00, 1, 1, 3, 8'h22, 32'h3C00A500, 0, 0, 0);
    vecs[7]  = mk(0, 0, 8'h00, 1, 1, 2, 8'h99, 32'h3C00A500, 0, 0, 0);
    vecs[8]  = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h3C00A500, 0, 0, 0);
    vecs[9]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h3C00A500, 0, 0, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h3C11A500, 1, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h2211A500, 1, 0, 0);
    // Host write collides with an eligible head on the same register.
    vecs[12] = mk(0, 0, 8'h00, 0, 1, 2, 8'h66, 32'h2211A500, 1, 0, 0);
    vecs[13] = mk(1, 2, 8'h55, 0, 0, 0, 8'h00, 32'h2255A500, 1, 0, 0);
    vecs[14] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h2266A500, 1, 0, 0);
    // Masked target while idle.
    vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 8'h77, 32'h2266A500, 1, 1, 0);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h2266A500, 1, 0, 0);
    // Masked target between two queued entries: count must not move.
    vecs[17] = mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h2266A500, 1, 0, 0);
    vecs[18] = mk(0, 0, 8'h00, 1, 1, 3, 8'hAB, 32'h2266A500, 1, 0, 0);
    vecs[19] = mk(0, 0, 8'h00, 1, 1, 0, 8'h77, 32'h2266A500, 1, 1, 0);
    vecs[20] = mk(0, 0, 8'h00, 1, 1, 2, 8'hCD, 32'h2266A500, 0, 0, 0);
    vecs[21] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h2266A500, 0, 0, 0);
    vecs[22] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'hAB66A500, 1, 0, 0);
    vecs[23] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 32'hABCDA500, 1, 0, 0);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset regs",    registers_packed, 32'h0);
    check("reset ready",   {31'b0, hw_ready}, 32'd1);
    check("reset err",     {31'b0, hw_err}, 32'd0);
    check("reset timeout", {31'b0, lock_timeout}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].busy,
            vecs[i].hv, vecs[i].hs, vecs[i].hd);
      step();
      check($sformatf("v%0d regs", i),    registers_packed, vecs[i].exp_regs);
      check($sformatf("v%0d ready", i),   {31'b0, hw_ready}, {31'b0, vecs[i].exp_ready});
      check($sformatf("v%0d err", i),     {31'b0, hw_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d timeout", i), {31'b0, lock_timeout}, {31'b0, vecs[i].exp_to});
    end

    // Watchdog: lock with two entries queued, hold busy past the timeout.
    drive(0, 0, 8'h00, 1, 1, 3, 8'hEE);
    step();
    check("to e0 regs",  registers_packed, 32'hABCDA500);
    check("to e0 ready", {31'b0, hw_ready}, 32'd1);
    drive(0, 0, 8'h00, 1, 1, 2, 8'hDD);
    step();
    check("to e1 ready", {31'b0, hw_ready}, 32'd0);
    drive(0, 0, 8'h00, 1, 0, 0, 8'h00);
    for (int k = 2; k <= 999; k++) step();
    check("to e999 timeout", {31'b0, lock_timeout}, 32'd0);
    check("to e999 regs",    registers_packed, 32'hABCDA500);
    step();
    check("to e1000 timeout", {31'b0, lock_timeout}, 32'd1);
    check("to e1000 regs",    registers_packed, 32'hABCDA500);
    step();
    check("stuck drain regs",    registers_packed, 32'hEECDA500);
    check("stuck drain ready",   {31'b0, hw_ready}, 32'd1);
    check("stuck drain timeout", {31'b0, lock_timeout}, 32'd1);

    // Asynchronous reset mid-drain: outputs clear without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst regs",    registers_packed, 32'h0);
    check("async rst ready",   {31'b0, hw_ready}, 32'd1);
    check("async rst err",     {31'b0, hw_err}, 32'd0);
    check("async rst timeout", {31'b0, lock_timeout}, 32'd0);
    drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    step();
    check("post rst regs",    registers_packed, 32'h0);
    check("post rst ready",   {31'b0, hw_ready}, 32'd1);
    check("post rst timeout", {31'b0, lock_timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Owns the I2C-visible register bank and shares its single write port between the I2C slave (host) and on-chip hardware producers (status/IO logic). Host writes always win and commit immediately. Hardware writes are buffered in a small FIFO and held off while a host bus transaction is in progress, so a multi-byte host write is atomic with respect to hardware updates. A watchdog releases the hold if the bus stays busy too long. The bank contents drive `registers_packed` to the IO block.

## Interface
- `NUM_REGS`, 4: registers in the bank.
- `DATA_W`, 8: register width.
- `SEL_W`, 2: register select width, equal to $clog2(NUM_REGS).
- `FIFO_DEPTH`, 2: hardware write buffer entries, at least 2 and a power of two.
- `HW_MASK`, 4'b1100: bit k=1 allows hardware to write register k.
- `TIMEOUT_CYC`, 1000: maximum `i2c_busy` hold cycles before the lock is released.

- `clock`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i2c_busy`  in  1  high from START to STOP of a host transaction.
- `i2c_we`  in  1  one-cycle host write strobe.
- `i2c_sel`  in  SEL_W  host target register.
- `i2c_wdata`  in  DATA_W  host write data.
- `hw_valid`  in  1  hardware write request.
- `hw_sel`  in  SEL_W  hardware target register.
- `hw_wdata`  in  DATA_W  hardware write data.
- `hw_ready`  out  1  FIFO can accept a request.
- `hw_err`  out  1  one-cycle pulse when an accepted request targets a register that `HW_MASK` forbids.
- `lock_timeout`  out  1  high while in STUCK.
- `registers_packed`  out  NUM_REGS*DATA_W  register k occupies bits [k*DATA_W +: DATA_W].

## Operation
- **Handshake.** A request is accepted on a rising edge where `hw_valid && hw_ready`.
  - `hw_ready = (count != FIFO_DEPTH)`, where `count` is the registered entry count. It has no combinational dependence on a same-cycle dequeue.
  - A request to a masked-off register is still accepted, but it is not enqueued; `hw_err` pulses on the next cycle.
- **Commit priority.**
  1. `i2c_we` writes `i2c_sel` in any state.
  2. Otherwise, if the FIFO is not empty and the state allows draining, the head entry is written and popped.
  - At most one bank write occurs per cycle.
- **FSM** (`arb_state_t`):
  - OPEN: draining allowed. `i2c_busy=1` moves to LOCKED and clears the timeout counter.
  - LOCKED: draining blocked. The counter increments each cycle. `i2c_busy=0` returns to OPEN. The counter reaching `TIMEOUT_CYC-1` with `i2c_busy` still high moves to STUCK.
  - STUCK: draining allowed and `lock_timeout=1`. `i2c_busy=0` returns to OPEN.
- **Simultaneous events.**
  - An `i2c_we` and a pending head in the same cycle: the host write commits and the head waits, with the FIFO unchanged.
  - An enqueue and a dequeue in the same cycle: `count` is unchanged and the pointers advance modulo `FIFO_DEPTH`.
  - A host write and a hardware write to the same register commit in order. The later commit wins.
- **Reset** (asynchronous, at any time, including mid-transaction or mid-drain):
  - All registers return to 0 and the FIFO is emptied; pending hardware writes are discarded.
  - State returns to OPEN.
  - Outputs after reset: `hw_ready=1`, `hw_err=0`, `lock_timeout=0`, `registers_packed=0`.

## Timing
- Host write strobe at edge N: the data is visible on `registers_packed` after edge N.
- Hardware request accepted at edge N into an empty FIFO in OPEN, with no host write at N+1: the data is visible after edge N+1. The minimum latency is one cycle.
- `i2c_busy` rising at edge N: the state is LOCKED after N. A head that would have drained at edge N+1 does not drain.
- `i2c_busy` falling: the state is OPEN after that edge, and draining resumes on the following edge at one entry per cycle.
- Timeout: STUCK is reached `TIMEOUT_CYC` cycles after entering LOCKED if `i2c_busy` stays high.
- `hw_err` asserts the cycle after the accepting edge, for exactly one cycle.

## Structure
- Package `reg_arb_pkg` holds:
  - the `arb_state_t` enum (OPEN, LOCKED, STUCK);
  - the `DATA_W`/`SEL_W` defaults;
  - the typedef `hw_wr_t` struct {sel, data}.
- Sub-module `wr_fifo`: a synchronous FIFO of `hw_wr_t`, parameterised by depth, with push/pop/full/empty/count outputs and asynchronous active-low reset.
- The arbiter contains the FSM, the timeout counter, the bank registers, and the mask check.

## Test plan
- Reset release, then host writes 0xA5 to reg 1 → `registers_packed[15:8]=0xA5` one cycle later; all other bytes 0.
- Hardware writes 0x3C to reg 3 while idle → `hw_ready=1`; `registers_packed[31:24]=0x3C` one cycle after acceptance.
- Hold `i2c_busy=1`, push two hardware writes (reg 2=0x11, reg 3=0x22), then a third → `hw_ready=0` on the third; no bank change until `i2c_busy` drops; then reg 2 and reg 3 update on consecutive cycles.
- Host write reg 2=0x55 in the same cycle that FIFO head reg 2=0x66 is eligible → reg 2=0x55 first, then 0x66 the next cycle.
- Hardware write to reg 0 (masked) → `hw_err` pulses once; reg 0 unchanged; FIFO count unchanged.
- Hold `i2c_busy` for `TIMEOUT_CYC`+5 cycles with one entry queued → `lock_timeout=1` and the entry drains; assert `reset_n=0` mid-drain → all outputs return to their reset values immediately.
